hum_actuator: RTL and testbench

Actuator sequencer that consumes the 2-bit humidity `status` code (0 idle, 1 humidify, 2 dehumidify, 3 sensor error) and drives the humidifier and dehumidifier relay outputs. It sits between the humidity comparator and the relay pins. It enforces:
- a minimum run time and a dead-time cooldown between activations;
- mutual exclusion of the two relays;
- a filtered, latched fault on persistent sensor errors that only an explicit clear releases.

---
 rtl/hum_actuator.sv | 173 +++++++++++++++++
 tb/tb_hum_actuator.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hum_actuator.sv
// -----------------------------------------------------------------------------
// hum_actuator
//
// Sequences the humidifier and dehumidifier relays from the 2-bit humidity
// status code (0 idle, 1 humidify, 2 dehumidify, 3 sensor error). It
// guarantees a minimum relay on-time, a dead-time cooldown after every
// deactivation, mutual exclusion of the two relays, and a filtered, latched
// fault on persistent sensor errors.
//
// Parameters:
//   MIN_ON_CYCLES   minimum consecutive cycles a relay stays energised (>=1)
//   DEAD_CYCLES     cooldown cycles with both relays off after deactivation (>=1)
//   ERR_FILTER      consecutive status==3 cycles needed to latch a fault (>=1)
//
// Ports:
//   clk              system clock, rising edge
//   rst_n            synchronous active-low reset
//   status[1:0]      demand code from the humidity comparator
//   enable           master enable; low forces the relays off
//   fault_clr        single-cycle request to leave FAULT
//   humidifier_on    humidifier relay drive (registered)
//   dehumidifier_on  dehumidifier relay drive (registered)
//   fault            latched sensor-fault flag (registered)
//   state[2:0]       current state (IDLE=0 HUMID=1 DEHUMID=2 DEAD=3 FAULT=4)
// -----------------------------------------------------------------------------
module hum_actuator #(
  parameter int MIN_ON_CYCLES = 8,
  parameter int DEAD_CYCLES   = 4,
  parameter int ERR_FILTER    = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] status,
  input  logic       enable,
  input  logic       fault_clr,
  output logic       humidifier_on,
  output logic       dehumidifier_on,
  output logic       fault,
  output logic [2:0] state
);

  localparam int CNT_MAX = (MIN_ON_CYCLES > DEAD_CYCLES) ? MIN_ON_CYCLES : DEAD_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int EW      = $clog2(ERR_FILTER + 1);

  localparam logic [CW-1:0] MIN_ON_C = CW'(MIN_ON_CYCLES);
  localparam logic [CW-1:0] DEAD_C   = CW'(DEAD_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [EW-1:0] ERR_C    = EW'(ERR_FILTER);
  localparam logic [EW-1:0] ERR_ONE  = EW'(1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HUM   = 2'd1;
  localparam logic [1:0] ST_DEHUM = 2'd2;
  localparam logic [1:0] ST_ERR   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HUMID   = 3'd1,
    S_DEHUMID = 3'd2,
    S_DEAD    = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [CW-1:0] w_cnt_limit;
  logic [EW-1:0] r_err;
  logic [EW-1:0] w_err_next;
  logic          w_trip;
  logic          w_run_done;
  logic          w_dead_done;
  logic          r_hum;
  logic          r_dehum;
  logic          r_fault;

  // Error filter: counts consecutive status==3 samples, saturating. The trip
  // is evaluated on the incremented value so the ERR_FILTER-th error sample
  // enters FAULT on that very edge.
  always_comb begin
    w_err_next = '0;
    if (status == ST_ERR) begin
      w_err_next = (r_err == ERR_C) ? r_err : r_err + ERR_ONE;
    end
  end

  assign w_trip = (w_err_next == ERR_C);

  // r_cnt holds the number of completed cycles in the current timed state,
  // loaded with 1 on the entry edge.
  assign w_run_done  = (r_cnt >= MIN_ON_C);
  assign w_dead_done = (r_cnt >= DEAD_C);

  always_comb begin
    w_next = r_state;
    if (w_trip) begin
      w_next = S_FAULT;
    end else if (!enable && (r_state == S_HUMID || r_state == S_DEHUMID)) begin
      w_next = S_DEAD;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (enable && status == ST_HUM) begin
            w_next = S_HUMID;
          end else if (enable && status == ST_DEHUM) begin
            w_next = S_DEHUMID;
          end
        end
        S_HUMID: begin
          if (w_run_done && status != ST_HUM) begin
            w_next = S_DEAD;
          end
        end
        S_DEHUMID: begin
          if (w_run_done && status != ST_DEHUM) begin
            w_next = S_DEAD;
          end
        end
        S_DEAD: begin
          if (w_dead_done) begin
            w_next = S_IDLE;
          end
        end
        S_FAULT: begin
          if (fault_clr && status != ST_ERR) begin
            w_next = S_DEAD;
          end
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_cnt_limit = (r_state == S_DEAD) ? DEAD_C : MIN_ON_C;
    w_cnt_next  = r_cnt;
    if (w_next != r_state) begin
      w_cnt_next = (w_next == S_HUMID || w_next == S_DEHUMID || w_next == S_DEAD)
                   ? CNT_ONE : '0;
    end else if ((r_state == S_HUMID || r_state == S_DEHUMID || r_state == S_DEAD)
                 && r_cnt < w_cnt_limit) begin
      w_cnt_next = r_cnt + CNT_ONE;
    end
  end

  // Outputs are decoded from the next state so relays and fault change on the
  // same edge as the state; one-hot decode keeps the relays exclusive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_err   <= '0;
      r_hum   <= 1'b0;
      r_dehum <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_next;
      r_hum   <= (w_next == S_HUMID);
      r_dehum <= (w_next == S_DEHUMID);
      r_fault <= (w_next == S_FAULT);
    end
  end

  assign humidifier_on   = r_hum;
  assign dehumidifier_on = r_dehum;
  assign fault           = r_fault;
  assign state           = r_state;

endmodule

// File: tb/tb_hum_actuator.sv
// -----------------------------------------------------------------------------
// tb_hum_actuator
//
// Directed testbench for hum_actuator with default parameters
// (MIN_ON_CYCLES=8, DEAD_CYCLES=4, ERR_FILTER=3). Inputs change 1 ns after a
// rising edge and outputs are observed at the same point, so each observation
// reflects the edge just taken.
// -----------------------------------------------------------------------------
module tb_hum_actuator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] status;
  logic       enable;
  logic       fault_clr;
  logic       humidifier_on;
  logic       dehumidifier_on;
  logic       fault;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  hum_actuator #(
    .MIN_ON_CYCLES(8),
    .DEAD_CYCLES  (4),
    .ERR_FILTER   (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .status         (status),
    .enable         (enable),
    .fault_clr      (fault_clr),
    .humidifier_on  (humidifier_on),
    .dehumidifier_on(dehumidifier_on),
    .fault          (fault),
    .state          (state)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0; status = 2'd0; enable = 1'b0; fault_clr = 1'b0;
    tick; tick;
    rst_n = 1'b1; enable = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; status = 2'd1; enable = 1'b1; fault_clr = 1'b0;
    tick; tick;
    checks++;
    if (state !== 3'd0 || humidifier_on !== 1'b0 || dehumidifier_on !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got state=%0d hum=%b dehum=%b fault=%b expected 0/0/0/0",
               state, humidifier_on, dehumidifier_on, fault);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic_run;
    int bad;
    do_reset;
    status = 2'd1;
    tick;
    checks++;
    if (state !== 3'd1 || humidifier_on !== 1'b1) begin
      errors++;
      $display("FAIL basic_activate: got state=%0d hum=%b expected 1/1", state, humidifier_on);
    end
    bad = 0;
    for (int i = 1; i < 20; i++) begin
      tick;
      if (humidifier_on !== 1'b1 || state !== 3'd1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL basic_hold: got %0d bad cycles expected 0", bad);
    end
    status = 2'd0;
    tick;
    checks++;
    if (state !== 3'd3 || humidifier_on !== 1'b0) begin
      errors++;
      $display("FAIL basic_release: got state=%0d hum=%b expected 3/0", state, humidifier_on);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (state !== 3'd3) bad++;
    end
    tick;
    checks++;
    if (bad != 0 || state !== 3'd0) begin
      errors++;
      $display("FAIL basic_dead: got bad=%0d final_state=%0d expected 0/0", bad, state);
    end
  endtask

  task automatic test_min_on;
    int high_cnt;
    int dead_cnt;
    do_reset;
    status = 2'd2;
    high_cnt = 0;
    dead_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (i == 2) status = 2'd0;
      tick;
      if (dehumidifier_on === 1'b1) high_cnt++;
      if (state === 3'd3) dead_cnt++;
    end
    checks++;
    if (high_cnt != 8) begin
      errors++;
      $display("FAIL min_on_len: got %0d high cycles expected 8", high_cnt);
    end
    checks++;
    if (dead_cnt != 4 || state !== 3'd0) begin
      errors++;
      $display("FAIL min_on_dead: got dead=%0d state=%0d expected 4/0", dead_cnt, state);
    end
  endtask

  task automatic test_swap;
    int low_cnt;
    int both;
    int done;
    do_reset;
    both = 0;
    status = 2'd1;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (humidifier_on === 1'b1 && dehumidifier_on === 1'b1) both++;
    end
    status = 2'd2;
    tick;
    checks++;
    if (humidifier_on !== 1'b0 || state !== 3'd3) begin
      errors++;
      $display("FAIL swap_fall: got hum=%b state=%0d expected 0/3", humidifier_on, state);
    end
    low_cnt = 1;
    done = 0;
    for (int i = 0; i < 20 && done == 0; i++) begin
      tick;
      if (humidifier_on === 1'b1 && dehumidifier_on === 1'b1) both++;
      if (dehumidifier_on === 1'b1) done = 1;
      else if (humidifier_on === 1'b0) low_cnt++;
    end
    checks++;
    if (done == 0 || low_cnt != 5 || state !== 3'd2) begin
      errors++;
      $display("FAIL swap_gap: got rose=%0d low=%0d state=%0d expected 1/5/2", done, low_cnt, state);
    end
    for (int i = 0; i < 10; i++) begin
      tick;
      if (humidifier_on === 1'b1 && dehumidifier_on === 1'b1) both++;
    end
    checks++;
    if (both != 0) begin
      errors++;
      $display("FAIL swap_exclusive: got %0d overlap cycles expected 0", both);
    end
  endtask

  task automatic test_error_filter;
    logic [1:0] seq [6];
    int bad;
    seq = '{2'd3, 2'd3, 2'd0, 2'd3, 2'd3, 2'd3};
    do_reset;
    status = 2'd1;
    tick;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      status = seq[i];
      tick;
      if (fault !== 1'b0 || humidifier_on !== 1'b1 || state !== 3'd1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL err_prefilter: got %0d bad cycles expected 0", bad);
    end
    status = seq[5];
    tick;
    checks++;
    if (fault !== 1'b1 || humidifier_on !== 1'b0 || state !== 3'd4) begin
      errors++;
      $display("FAIL err_trip: got fault=%b hum=%b state=%0d expected 1/0/4", fault, humidifier_on, state);
    end
    fault_clr = 1'b1;
    tick;
    fault_clr = 1'b0;
    checks++;
    if (fault !== 1'b1 || state !== 3'd4) begin
      errors++;
      $display("FAIL err_clr_ignored: got fault=%b state=%0d expected 1/4", fault, state);
    end
    status = 2'd0;
    tick;
    checks++;
    if (fault !== 1'b1 || state !== 3'd4) begin
      errors++;
      $display("FAIL err_latched: got fault=%b state=%0d expected 1/4", fault, state);
    end
    fault_clr = 1'b1;
    tick;
    fault_clr = 1'b0;
    checks++;
    if (fault !== 1'b0 || state !== 3'd3) begin
      errors++;
      $display("FAIL err_clear: got fault=%b state=%0d expected 0/3", fault, state);
    end
  endtask

  task automatic test_simultaneous;
    do_reset;
    status = 2'd3;
    fault_clr = 1'b1;
    tick; tick; tick;
    fault_clr = 1'b0;
    checks++;
    if (fault !== 1'b1 || state !== 3'd4) begin
      errors++;
      $display("FAIL clr_on_trip: got fault=%b state=%0d expected 1/4", fault, state);
    end
    do_reset;
    status = 2'd1;
    tick;
    status = 2'd3;
    tick; tick;
    enable = 1'b0;
    tick;
    checks++;
    if (fault !== 1'b1 || state !== 3'd4 || humidifier_on !== 1'b0) begin
      errors++;
      $display("FAIL trip_and_disable: got fault=%b state=%0d hum=%b expected 1/4/0",
               fault, state, humidifier_on);
    end
  endtask

  task automatic test_enable_drop;
    int bad;
    do_reset;
    status = 2'd2;
    tick; tick; tick;
    enable = 1'b0;
    tick;
    checks++;
    if (dehumidifier_on !== 1'b0 || state !== 3'd3) begin
      errors++;
      $display("FAIL en_drop_off: got dehum=%b state=%0d expected 0/3", dehumidifier_on, state);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (state !== 3'd3) bad++;
    end
    tick;
    checks++;
    if (bad != 0 || state !== 3'd0) begin
      errors++;
      $display("FAIL en_drop_dead: got bad=%0d state=%0d expected 0/0", bad, state);
    end
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (state !== 3'd0 || dehumidifier_on !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL en_low_idle: got %0d bad cycles expected 0", bad);
    end
    enable = 1'b1;
    tick;
    checks++;
    if (state !== 3'd2 || dehumidifier_on !== 1'b1) begin
      errors++;
      $display("FAIL en_resume: got state=%0d dehum=%b expected 2/1", state, dehumidifier_on);
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    status = 2'd3;
    tick; tick; tick;
    rst_n = 1'b0;
    tick;
    checks++;
    if (state !== 3'd0 || fault !== 1'b0 || humidifier_on !== 1'b0 || dehumidifier_on !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_fault: got state=%0d fault=%b hum=%b dehum=%b expected 0/0/0/0",
               state, fault, humidifier_on, dehumidifier_on);
    end
    rst_n = 1'b1;
    status = 2'd1;
    tick;
    checks++;
    if (state !== 3'd1 || humidifier_on !== 1'b1) begin
      errors++;
      $display("FAIL rst_resume_hum: got state=%0d hum=%b expected 1/1", state, humidifier_on);
    end
    tick;
    rst_n = 1'b0;
    tick;
    checks++;
    if (state !== 3'd0 || humidifier_on !== 1'b0 || fault !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_humid: got state=%0d hum=%b fault=%b expected 0/0/0", state, humidifier_on, fault);
    end
    rst_n = 1'b1;
    status = 2'd2;
    tick;
    checks++;
    if (state !== 3'd2 || dehumidifier_on !== 1'b1) begin
      errors++;
      $display("FAIL rst_resume_dehum: got state=%0d dehum=%b expected 2/1", state, dehumidifier_on);
    end
  endtask

  initial begin
    rst_n = 1'b0; status = 2'd0; enable = 1'b0; fault_clr = 1'b0;
    test_reset;
    test_basic_run;
    test_min_on;
    test_swap;
    test_error_filter;
    test_simultaneous;
    test_enable_drop;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
